// File: rtl/ysyx_22050612_ifetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, fetch FSM encoding, queue entry layout.
package ysyx_22050612_ifetch_pkg;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    localparam int ENT_W = XLEN + ILEN + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction
endpackage

// File: rtl/ysyx_22050612_ifetch_ifq.sv
// DEPTH-entry synchronous instruction queue; flush dominates push and pop.
module ysyx_22050612_ifq
    import ysyx_22050612_ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_count
);
    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_head    = r_mem[r_rp];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !i_flush && w_do_push) r_mem[r_wp] <= i_push_data;
    end
endmodule

// File: rtl/ysyx_22050612_ifetch.sv
// Fetch stage: PC, single-outstanding imem request FSM, instruction queue to decode.
// Optional YSYX_22050612_IFETCH_PERF_EN adds fetch/flush/stall performance counters.
module ysyx_22050612_ifetch
    import ysyx_22050612_ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic            out_fault
`ifdef YSYX_22050612_IFETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_flush_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_flt_pend;
    logic            r_stale;

    logic            w_hs;
    logic            w_misal;
    logic            w_outst;
    logic            w_push_rsp;
    logic            w_push_flt;
    logic            w_pop;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;
    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_cnt;

    assign imem_req_valid = (r_state == S_REQ) && !w_full;
    assign imem_req_addr  = r_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_misal        = pc_misaligned(redirect_pc[1:0]);

    // A request is still in flight after this edge unless its response lands now.
    assign w_outst = ((r_state == S_REQ) && w_hs) ||
                     (((r_state == S_WAIT) || (r_state == S_DROP) ||
                       ((r_state == S_HALT) && r_stale)) && !imem_rsp_valid);

    assign w_push_rsp = !redirect_valid && (r_state == S_WAIT) && imem_rsp_valid;
    assign w_push_flt = !redirect_valid && (r_state == S_HALT) && r_flt_pend;
    assign w_pop      = out_valid && out_ready;

    always_comb begin
        w_entry.pc    = r_pc;
        w_entry.inst  = imem_rsp_err ? '0 : imem_rsp_data;
        w_entry.fault = imem_rsp_err;
        if (w_push_flt) begin
            w_entry.inst  = '0;
            w_entry.fault = 1'b1;
        end
    end

    ysyx_22050612_ifq #(.DEPTH(DEPTH)) u_ifq (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push_rsp || w_push_flt),
        .i_push_data (w_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_cnt)
    );

    assign out_valid = (w_cnt != '0);
    assign out_pc    = w_empty ? '0 : w_head.pc;
    assign out_inst  = w_empty ? '0 : w_head.inst;
    assign out_fault = !w_empty && w_head.fault;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_flt_pend <= 1'b0;
            r_stale    <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (w_misal) begin
                // Fault entry is pushed from HALT; any in-flight response is swallowed there.
                r_state    <= S_HALT;
                r_flt_pend <= 1'b1;
                r_stale    <= w_outst;
            end else begin
                r_state    <= w_outst ? S_DROP : S_REQ;
                r_flt_pend <= 1'b0;
                r_stale    <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ:  if (w_hs) r_state <= S_WAIT;
                S_WAIT: if (imem_rsp_valid) begin
                    r_pc    <= r_pc + 64'd4;
                    r_state <= imem_rsp_err ? S_HALT : S_REQ;
                end
                S_DROP: if (imem_rsp_valid) r_state <= S_REQ;
                S_HALT: begin
                    r_flt_pend <= 1'b0;
                    if (imem_rsp_valid) r_stale <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef YSYX_22050612_IFETCH_PERF_EN
    logic [63:0] r_perf_fetch;
    logic [63:0] r_perf_flush;
    logic [63:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push_rsp)                     r_perf_fetch <= r_perf_fetch + 64'd1;
            if (redirect_valid)                 r_perf_flush <= r_perf_flush + 64'd1;
            if ((r_state == S_REQ) && w_full)   r_perf_stall <= r_perf_stall + 64'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_stall_cnt = r_perf_stall;
`endif
endmodule
